// File: rtl/trig_scheduler.sv
// Trigger scheduler: merges external requests and calibration bursts
// into pretrig/trigger sequences with a fixed lead and dead time.
module trig_scheduler #(
    parameter int PRE_WIDTH = 3,
    parameter int PRE_LEAD  = 5,
    parameter int DEAD_TIME = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        ext_req,
    input  logic        cal_start,
    input  logic [15:0] ntrig,
    input  logic [7:0]  gap,
    input  logic        busy_in,
    output logic        pretrig,
    output logic        trigger,
    output logic        src,
    output logic        ack,
    output logic        ext_drop,
    output logic        done,
    output logic        busy,
    output logic [15:0] trig_count
);

    localparam int CMAX = (PRE_LEAD > DEAD_TIME) ? PRE_LEAD : DEAD_TIME;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        TRIG,
        DEAD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ext_pend;
    logic [15:0]   cal_left;
    logic [7:0]    gap_cnt;
    logic [7:0]    gap_q;
    logic          cal_last;

    logic cal_due;
    logic go;
    logic acc_ext;
    logic acc_cal;
    logic cal_zero;

    assign cal_due  = (cal_left != 16'd0) && (gap_cnt == 8'd0);
    assign go       = (state == IDLE) && ena && !busy_in;
    assign acc_ext  = go && ext_pend;
    assign acc_cal  = go && !ext_pend && cal_due;
    assign cal_zero = cal_start && (cal_left == 16'd0)
                      && (ntrig == 16'd0);

    // Pending external request and calibration burst bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_pend <= 1'b0;
            ext_drop <= 1'b0;
            cal_left <= 16'd0;
            gap_cnt  <= 8'd0;
            gap_q    <= 8'd0;
            cal_last <= 1'b0;
        end else begin
            ext_drop <= ext_req && ext_pend && !acc_ext;
            if (acc_ext)
                ext_pend <= ext_req;
            else if (ext_req)
                ext_pend <= 1'b1;
            if (acc_cal) begin
                cal_left <= cal_left - 16'd1;
                gap_cnt  <= gap_q;
                cal_last <= (cal_left == 16'd1);
            end else if (cal_start && cal_left == 16'd0) begin
                cal_left <= ntrig;
                gap_cnt  <= gap;
                gap_q    <= gap;
            end else if (cal_left != 16'd0 && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    // Sequence FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pretrig    <= 1'b0;
            trigger    <= 1'b0;
            src        <= 1'b0;
            ack        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            trig_count <= 16'd0;
        end else begin
            ack     <= 1'b0;
            trigger <= 1'b0;
            done    <= cal_zero;
            unique case (state)
                IDLE: begin
                    if (acc_ext || acc_cal) begin
                        state   <= PRE;
                        cnt     <= '0;
                        src     <= acc_cal;
                        ack     <= 1'b1;
                        pretrig <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                PRE: begin
                    if (cnt == CW'(PRE_LEAD - 1)) begin
                        state      <= TRIG;
                        pretrig    <= 1'b0;
                        trigger    <= 1'b1;
                        trig_count <= trig_count + 16'd1;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        pretrig <= (int'(cnt) + 1 < PRE_WIDTH);
                    end
                end
                TRIG: begin
                    state <= DEAD;
                    cnt   <= '0;
                    if (src && cal_last)
                        done <= 1'b1;
                end
                DEAD: begin
                    if (cnt == CW'(DEAD_TIME - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_scheduler.sv
// Bench for trig_scheduler: timeline model checked every cycle plus
// directed scenarios with hand-computed cycle numbers.
module tb_trig_scheduler;

    localparam int PW = 3;
    localparam int PL = 5;
    localparam int DT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b1;
    logic        ext_req = 1'b0;
    logic        cal_start = 1'b0;
    logic [15:0] ntrig = 16'd0;
    logic [7:0]  gap = 8'd0;
    logic        busy_in = 1'b0;
    logic        pretrig, trigger, src, ack, ext_drop, done, busy;
    logic [15:0] trig_count;

    trig_scheduler #(
        .PRE_WIDTH(PW),
        .PRE_LEAD (PL),
        .DEAD_TIME(DT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .ext_req   (ext_req),
        .cal_start (cal_start),
        .ntrig     (ntrig),
        .gap       (gap),
        .busy_in   (busy_in),
        .pretrig   (pretrig),
        .trigger   (trigger),
        .src       (src),
        .ack       (ack),
        .ext_drop  (ext_drop),
        .done      (done),
        .busy      (busy),
        .trig_count(trig_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int trig_q[$];
    int src_q[$];
    int done_q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic int tq(int i);
        return (i < trig_q.size()) ? trig_q[i] : -1;
    endfunction

    function automatic int sq(int i);
        return (i < src_q.size()) ? src_q[i] : -1;
    endfunction

    function automatic int dq(int i);
        return (i < done_q.size()) ? done_q[i] : -1;
    endfunction

    // Model: a sequence is an age timeline since acceptance
    int  m_age = -1;
    bit  m_pend = 0;
    int  m_left = 0;
    int  m_gcnt = 0;
    int  m_gap = 0;
    bit  m_last = 0;
    bit  m_src = 0;
    int  m_count = 0;
    bit  e_pretrig = 0, e_trig = 0, e_ack = 0, e_drop = 0;
    bit  e_done = 0, e_busy = 0;

    always @(posedge clk) begin : model
        int a;
        bit go, acc_e, acc_c;
        if (!rst) begin
            m_age = -1; m_pend = 0; m_left = 0; m_gcnt = 0;
            m_last = 0; m_src = 0; m_count = 0;
            e_pretrig = 0; e_trig = 0; e_ack = 0;
            e_drop = 0; e_done = 0; e_busy = 0;
        end else begin
            a = m_age;
            go = (a < 0) && ena && !busy_in;
            acc_e = go && m_pend;
            acc_c = go && !m_pend && m_left > 0 && m_gcnt == 0;
            e_done = (a == PL && m_src && m_last)
                     || (cal_start && m_left == 0 && ntrig == 0);
            e_drop = ext_req && m_pend && !acc_e;
            m_pend = acc_e ? ext_req : (m_pend || ext_req);
            if (acc_c) begin
                m_last = (m_left == 1);
                m_left = m_left - 1;
                m_gcnt = m_gap;
            end else if (cal_start && m_left == 0) begin
                m_left = ntrig;
                m_gcnt = gap;
                m_gap = gap;
            end else if (m_left > 0 && m_gcnt > 0) begin
                m_gcnt = m_gcnt - 1;
            end
            if (acc_e || acc_c) begin
                m_age = 0;
                m_src = acc_c;
            end else if (a >= 0) begin
                m_age = (a + 1 > PL + DT) ? -1 : a + 1;
            end
            e_ack = acc_e || acc_c;
            e_pretrig = m_age >= 0 && m_age < PW;
            e_trig = m_age == PL;
            e_busy = m_age >= 0;
            if (e_trig) m_count = (m_count + 1) % 65536;
        end
    end

    // Compare every cycle and log trigger/done events
    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("pretrig", 32'(pretrig), 32'(e_pretrig));
            check("trigger", 32'(trigger), 32'(e_trig));
            check("src", 32'(src), 32'(m_src));
            check("ack", 32'(ack), 32'(e_ack));
            check("ext_drop", 32'(ext_drop), 32'(e_drop));
            check("done", 32'(done), 32'(e_done));
            check("busy", 32'(busy), 32'(e_busy));
            check("trig_count", 32'(trig_count), 32'(m_count));
            if (trigger === 1'b1) begin
                trig_q.push_back(cyc);
                src_q.push_back(int'(src));
            end
            if (done === 1'b1) done_q.push_back(cyc);
        end
    end

    task automatic goto(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_ext(int n);
        goto(n);
        ext_req = 1'b1;
        goto(n + 1);
        ext_req = 1'b0;
    endtask

    initial begin : main
        int k;
        int d;
        goto(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_pretrig", 32'(pretrig), 0);
        check("rst_count", 32'(trig_count), 0);
        goto(4);
        rst = 1'b1;

        pulse_ext(10);
        goto(11);
        check("lat_ack11", 32'(ack), 0);
        goto(12);
        check("lat_ack12", 32'(ack), 1);
        check("lat_pre12", 32'(pretrig), 1);
        goto(14);
        check("lat_pre14", 32'(pretrig), 1);
        goto(15);
        check("lat_pre15", 32'(pretrig), 0);
        goto(17);
        check("lat_trig17", 32'(trigger), 1);
        goto(33);
        check("lat_busy33", 32'(busy), 1);
        goto(34);
        check("lat_busy34", 32'(busy), 0);
        check("lat_count", 32'(trig_count), 1);

        goto(40);
        cal_start = 1'b1; ntrig = 16'd3; gap = 8'd30;
        goto(41);
        cal_start = 1'b0;
        goto(150);
        check("cal_n", trig_q.size(), 4);
        check("cal_t1", tq(1), 77);
        check("cal_t2", tq(2), 108);
        check("cal_t3", tq(3), 139);
        check("cal_src1", sq(1), 1);
        check("cal_src3", sq(3), 1);
        check("cal_done", dq(0), 140);

        goto(160);
        cal_start = 1'b1; ntrig = 16'd1; gap = 8'd10;
        goto(161);
        cal_start = 1'b0;
        pulse_ext(170);
        goto(210);
        check("prio_t_ext", tq(4), 177);
        check("prio_src_ext", sq(4), 0);
        check("prio_t_cal", tq(5), 200);
        check("prio_src_cal", sq(5), 1);
        check("prio_done", dq(1), 201);

        pulse_ext(220);
        pulse_ext(225);
        pulse_ext(230);
        goto(231);
        check("drop231", 32'(ext_drop), 1);
        goto(268);
        check("drop_n", trig_q.size(), 8);
        check("drop_t1", tq(6), 227);
        check("drop_t2", tq(7), 250);

        goto(270);
        busy_in = 1'b1;
        pulse_ext(272);
        goto(300);
        check("blk_pre300", 32'(pretrig), 0);
        goto(320);
        busy_in = 1'b0;
        check("blk_ack320", 32'(ack), 0);
        goto(321);
        check("blk_ack321", 32'(ack), 1);

        goto(350);
        ena = 1'b0;
        pulse_ext(352);
        goto(400);
        ena = 1'b1;
        check("ena_ack400", 32'(ack), 0);
        goto(401);
        check("ena_ack401", 32'(ack), 1);
        goto(403);
        busy_in = 1'b1; ena = 1'b0;
        goto(406);
        check("noabort_trig", 32'(trigger), 1);
        busy_in = 1'b0; ena = 1'b1;

        goto(430);
        cal_start = 1'b1; ntrig = 16'd0; gap = 8'd5;
        goto(431);
        cal_start = 1'b0;
        check("zero_done", 32'(done), 1);
        goto(440);
        check("zero_n", trig_q.size(), 10);

        cal_start = 1'b1; ntrig = 16'd245; gap = 8'd0;
        goto(441);
        cal_start = 1'b0;
        goto(500);
        check("b2b_t1", tq(10), 447);
        check("b2b_t2", tq(11), 470);
        k = 0;
        while (done !== 1'b1 && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check("burst_done_seen", 32'(k < 8000), 1);
        check("burst_done_cyc", cyc, 6060);
        check("burst_count", 32'(trig_count), 32'h00FF);

        d = cyc;
        pulse_ext(d + 20);
        goto(d + 23);
        check("rst_mid_pre", 32'(pretrig), 1);
        rst = 1'b0;
        goto(d + 24);
        rst = 1'b1;
        check("rstm_pretrig", 32'(pretrig), 0);
        check("rstm_busy", 32'(busy), 0);
        check("rstm_count", 32'(trig_count), 0);
        check("rstm_ack", 32'(ack), 0);
        goto(d + 60);
        check("rstm_no_trig", trig_q.size(), 255);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_scheduler.md
TRIG_SCHEDULER -- requirements
Module: trig_scheduler

Interface
REQ-001 Parameter PRE_WIDTH, default 3: pretrig pulse length in cycles; SHALL satisfy 1 <= PRE_WIDTH < PRE_LEAD.
REQ-002 Parameter PRE_LEAD, default 5: cycles from the first pretrig-high cycle to the trigger-high cycle.
REQ-003 Parameter DEAD_TIME, default 16: cycles of dead time after each trigger; minimum 1.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 ena  in  1  global enable; low blocks acceptance of new sequences.
REQ-007 ext_req  in  1  external trigger request, single-cycle pulse.
REQ-008 cal_start  in  1  pulse that starts an internal calibration burst.
REQ-009 ntrig  in  16  number of calibration triggers per burst, sampled on cal_start.
REQ-010 gap  in  8  minimum idle cycles between calibration acceptances, sampled on cal_start.
REQ-011 busy_in  in  1  downstream busy; high blocks acceptance.
REQ-012 pretrig  out  1  pre-trigger pulse.
REQ-013 trigger  out  1  main trigger, one cycle wide.
REQ-014 src  out  1  source of the current sequence: 0 = external, 1 = calibration; held while busy.
REQ-015 ack  out  1  one-cycle pulse on acceptance of a sequence.
REQ-016 ext_drop  out  1  one-cycle pulse when an ext_req is discarded.
REQ-017 done  out  1  one-cycle pulse at the end of a calibration burst.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.
REQ-019 trig_count  out  16  count of issued triggers.

Function
REQ-020 FSM states SHALL be IDLE, PRE, TRIG, DEAD; every output SHALL be registered.
REQ-021 ext_req sampled high SHALL set ext_pend in the next cycle.
- If ext_pend is already set, the request SHALL be dropped and ext_drop SHALL pulse.
REQ-022 Calibration burst start:
- cal_start while cal_left == 0 SHALL load cal_left = ntrig and gap_cnt = gap.
- cal_start while a burst is active SHALL be ignored.
REQ-023 While cal_left > 0 and gap_cnt > 0, gap_cnt SHALL decrement each cycle; cal_due = (cal_left > 0) && (gap_cnt == 0).
REQ-024 In IDLE, when ena && !busy_in && (ext_pend || cal_due), the FSM SHALL accept a sequence.
- ext_pend SHALL win over cal_due; the losing cal_due stays pending.
REQ-025 On acceptance:
- FSM moves to PRE; src is latched; ack pulses in the first PRE cycle.
- External acceptance clears ext_pend.
- Calibration acceptance decrements cal_left and reloads gap_cnt = gap.
REQ-026 PRE SHALL last PRE_LEAD cycles; pretrig SHALL be high for the first PRE_WIDTH of those cycles.
REQ-027 TRIG SHALL last 1 cycle with trigger high; trig_count increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-028 DEAD SHALL last DEAD_TIME cycles, then the FSM returns to IDLE.
REQ-029 Latency: ext_req high in cycle N with the FSM idle and unblocked gives:
- pretrig high in cycles N+2 .. N+1+PRE_WIDTH;
- trigger high in cycle N+2+PRE_LEAD;
- IDLE again in cycle N+3+PRE_LEAD+DEAD_TIME.
REQ-030 done SHALL pulse in the cycle after the TRIG cycle of the last calibration trigger (cal_left == 0).
- cal_start with ntrig == 0 SHALL pulse done in the next cycle and issue no trigger.
REQ-031 ena or busy_in going low-to-high mid-sequence SHALL NOT abort the sequence; pending requests SHALL be retained.
REQ-032 Back-to-back gap: the gap counter SHALL run during PRE/TRIG/DEAD, so gap = 0 gives calibration sequences spaced exactly by the sequence length.

Reset
REQ-033 rst low at a rising edge SHALL, at any point including mid-sequence:
- force IDLE;
- clear ext_pend, cal_left, gap_cnt and trig_count;
- drive pretrig, trigger, src, ack, ext_drop, done and busy to 0 in the following cycle.

Verification
REQ-034 Default parameters, ext_req pulse at cycle 10 -> ack and pretrig at cycle 12, pretrig low at 15, trigger at 17, busy low from 34, trig_count = 1.
REQ-035 cal_start with ntrig = 3, gap = 30 -> exactly 3 triggers with src = 1, trigger spacing 31 cycles, done one cycle after the third trigger.
REQ-036 ext_req in the same cycle cal_due goes high -> external sequence first (src = 0); calibration sequence starts at the first IDLE after the dead time.
REQ-037 Two ext_req pulses during one sequence -> first retained, second gives ext_drop; exactly 2 triggers total.
REQ-038 busy_in held high for 50 cycles with ext_pend set -> no pretrig; acceptance 1 cycle after busy_in falls. ena low -> same behaviour.
REQ-039 rst low during PRE (pretrig high), trig_count = 0x00FF -> next cycle all outputs 0 and trig_count = 0; no trigger is emitted.
